mips_cpu_instruction_queue: RTL and testbench
=============================================

// Module: mips_cpu_instruction_queue
// PURPOSE
//  Parametrised prefetch queue between instruction memory and control/decode; replaces single-word instruction latch.
//  Buffers up to DEPTH fetched words with their PC and presents the head entry pre-split into MIPS fields.
//  Valid/ready handshake on both sides; synchronous flush discards all entries on branch/jump redirect.
// PARAMETERS
//  DEPTH     4   entries; power of two, >=2
//  PC_WIDTH  32  width of PC tag stored with each word
// PORTS
//  clk          in   1         rising-edge clock
//  reset_n      in   1         asynchronous active-low reset
//  flush        in   1         discard all entries at next edge
//  in_valid     in   1         fetch word valid
//  in_ready     out  1         queue accepts word this cycle
//  in_instr     in   32        fetched instruction word
//  in_pc        in   PC_WIDTH  PC of fetched word
//  out_valid    out  1         head entry valid
//  out_ready    in   1         decode consumes head this cycle
//  out_pc       out  PC_WIDTH  PC of head
//  opcode       out  6         head[31:26]
//  source_1     out  5         head[25:21]
//  source_2     out  5         head[20:16]
//  dest         out  5         head[15:11]
//  shamt        out  5         head[10:6]
//  funct        out  6         head[5:0]
//  immediate    out  16        head[15:0]
//  jmp_address  out  26        head[25:0]
//  count        out  clog2(DEPTH+1)  stored entries
// BEHAVIOUR
//  - Reset (reset_n=0, async): wr_ptr=rd_ptr=0, count=0; out_valid=0, in_ready=1 after release. Storage array not reset.
//  - Field outputs and out_pc are driven 0 whenever out_valid=0 (defined values at reset/empty).
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on same edge.
//  - in_ready = (count<DEPTH) & ~flush. Full queue: in_ready=0 even if pop this cycle (no pass-through when full).
//  - out_valid = (count!=0) & ~flush (plus bypass term, see CONFIGURATION).
//  - Push: {in_pc,in_instr} written at wr_ptr; wr_ptr+1 mod DEPTH. Pop: rd_ptr+1 mod DEPTH.
//  - count: +1 push only, -1 pop only, unchanged push&pop. Never exceeds DEPTH, never below 0.
//  - Pointers log2(DEPTH) bits, wrap naturally; ordering strictly FIFO across wrap.
//  - flush=1: next edge wr_ptr=rd_ptr=0, count=0; concurrent in_valid ignored (in_ready=0); out_valid=0 during flush cycle, no pop.
//  - Latency (non-bypass): word pushed at edge N visible at head after edge N when queue empty.
//  - Head fields are combinational slices of storage[rd_ptr]; no extra register stage.
//  - Reset asserted mid-operation: all entries lost immediately; no partial state survives.
// CONFIGURATION
//  MIPS_IQ_BYPASS_EN defined: when count==0, ~flush, in_valid=1: out_valid=1 same cycle, fields/out_pc
//    taken directly from in_instr/in_pc (zero-latency fall-through). If out_ready also 1, word is consumed
//    and not written (count stays 0, pointers unchanged); if out_ready=0 word is pushed normally.
//  MIPS_IQ_BYPASS_EN undefined: no fall-through; empty queue always adds one cycle fetch-to-decode latency.
// TESTING
//  1. Reset, push 0x8C220004@pc 0x100 (no out_ready) -> next cycle out_valid=1, opcode=0x23, source_1=1, source_2=2, immediate=0x0004, out_pc=0x100, count=1.
//  2. Push 4 words, no pops -> count=4, in_ready=0; 5th in_valid ignored; pop all 4 -> same order, count=0, out_valid=0, fields=0.
//  3. Fill/drain 10 words with DEPTH=4 and random out_ready -> FIFO order across pointer wrap, count matches model each cycle.
//  4. count=2, push&pop same edge -> count stays 2, head advances to 2nd word; new word appears third.
//  5. count=3, flush=1 with in_valid=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0, out_valid=0.
//  6. Bypass: empty, in_valid=1 instr 0x0022182A, out_ready=1 -> with MIPS_IQ_BYPASS_EN same-cycle out_valid=1, funct=0x2A, dest=3, count stays 0; without it out_valid=0 that cycle, 1 next cycle.
//  7. reset_n pulsed low mid-stream (count=3) -> out_valid=0, count=0 immediately, asynchronously.

Source files
------------

// File: rtl/mips_cpu_instruction_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_instruction_queue
//  Description : Prefetch FIFO between instruction memory and decode. Holds
//                up to DEPTH {pc, instr} entries and presents the head entry
//                pre-split into MIPS instruction fields. Valid/ready on both
//                sides, synchronous flush for branch/jump redirects.
//                Optional zero-latency fall-through when empty is enabled by
//                defining MIPS_IQ_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_instruction_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [5:0]                   opcode,
    output logic [4:0]                   source_1,
    output logic [4:0]                   source_2,
    output logic [4:0]                   dest,
    output logic [4:0]                   shamt,
    output logic [5:0]                   funct,
    output logic [15:0]                  immediate,
    output logic [25:0]                  jmp_address,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH+1);
    localparam int                 c_ENT_W = PC_WIDTH + 32;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;
    logic [c_ENT_W-1:0] w_head_vis;

    assign w_empty = (r_count == '0);

`ifdef MIPS_IQ_BYPASS_EN
    // Empty queue: the incoming word is presented directly at the head.
    assign w_bypass = w_empty & ~flush & in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // No pass-through when full: a pop on the same edge does not free a slot.
    assign in_ready  = (r_count != c_FULL) & ~flush;
    assign out_valid = (~w_empty & ~flush) | w_bypass;

    // A bypassed word consumed the same cycle never touches storage.
    assign w_push = in_valid & in_ready & ~(w_bypass & out_ready);
    assign w_pop  = out_valid & out_ready & ~w_bypass;

    assign w_head     = w_bypass ? {in_pc, in_instr} : r_mem[r_rd_ptr];
    assign w_head_vis = out_valid ? w_head : '0;

    assign out_pc      = w_head_vis[c_ENT_W-1:32];
    assign opcode      = w_head_vis[31:26];
    assign source_1    = w_head_vis[25:21];
    assign source_2    = w_head_vis[20:16];
    assign dest        = w_head_vis[15:11];
    assign shamt       = w_head_vis[10:6];
    assign funct       = w_head_vis[5:0];
    assign immediate   = w_head_vis[15:0];
    assign jmp_address = w_head_vis[25:0];
    assign count       = r_count;

    // Storage array: written on push only, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_pc, in_instr};
        end
    end

    // Pointer and occupancy tracking; flush empties the queue at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_instruction_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_instruction_queue
//  Description : Self-checking bench for mips_cpu_instruction_queue (DEPTH=4).
//                Table of vectors for fill/drain, scoreboard model for the
//                random and corner-case sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_instruction_queue;

    localparam int DEPTH = 4;
`ifdef MIPS_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  source_1;
    logic [4:0]  source_2;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] jmp_address;
    logic [2:0]  count;

    int checks;
    int errors;
    logic [63:0] sb [$];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        int          e_cnt;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [11];

    mips_cpu_instruction_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .opcode      (opcode),
        .source_1    (source_1),
        .source_2    (source_2),
        .dest        (dest),
        .shamt       (shamt),
        .funct       (funct),
        .immediate   (immediate),
        .jmp_address (jmp_address),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare all head outputs against an expected {pc, instr} word.
    task automatic check_head(input logic [63:0] hd);
        chk("out_pc",      64'(out_pc),      64'(hd[63:32]));
        chk("opcode",      64'(opcode),      64'(hd[31:26]));
        chk("source_1",    64'(source_1),    64'(hd[25:21]));
        chk("source_2",    64'(source_2),    64'(hd[20:16]));
        chk("dest",        64'(dest),        64'(hd[15:11]));
        chk("shamt",       64'(shamt),       64'(hd[10:6]));
        chk("funct",       64'(funct),       64'(hd[5:0]));
        chk("immediate",   64'(immediate),   64'(hd[15:0]));
        chk("jmp_address", 64'(jmp_address), 64'(hd[25:0]));
    endtask

    // One cycle against the scoreboard model: drive, check, advance model.
    task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy, output logic acc);
        logic        byp;
        logic        e_ir;
        logic        e_ov;
        logic        pop;
        logic [63:0] hd;
        @(negedge clk);
        flush     = fl;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        #1;
        byp  = BYP && (sb.size() == 0) && !fl && iv;
        e_ir = (sb.size() < DEPTH) && !fl;
        e_ov = ((sb.size() != 0) && !fl) || byp;
        chk("in_ready",  64'(in_ready),  64'(e_ir));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("count",     64'(count),     64'(sb.size()));
        if (e_ov) hd = byp ? {pc, ins} : sb[0];
        else      hd = '0;
        check_head(hd);
        acc = iv && e_ir;
        pop = e_ov && ordy;
        if (fl) begin
            sb.delete();
        end else if (!(byp && pop)) begin
            if (pop) void'(sb.pop_front());
            if (acc) sb.push_back({pc, ins});
        end
    endtask

    logic        acc;
    logic        iv;
    logic [31:0] pend;
    int          sent;

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 32'h8C220004, 32'h100, 1'b0, 1'b1, BYP,  0, BYP ? 32'h8C220004 : 32'h0, BYP ? 32'h100 : 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 1, 32'h8C220004, 32'h100};
        tbl[2]  = '{1'b0, 1'b1, 32'h00221820, 32'h104, 1'b0, 1'b1, 1'b1, 1, 32'h8C220004, 32'h100};
        tbl[3]  = '{1'b0, 1'b1, 32'hAC430008, 32'h108, 1'b0, 1'b1, 1'b1, 2, 32'h8C220004, 32'h100};
        tbl[4]  = '{1'b0, 1'b1, 32'h08000040, 32'h10C, 1'b0, 1'b1, 1'b1, 3, 32'h8C220004, 32'h100};
        tbl[5]  = '{1'b0, 1'b1, 32'h12345678, 32'h110, 1'b0, 1'b0, 1'b1, 4, 32'h8C220004, 32'h100};
        tbl[6]  = '{1'b0, 1'b1, 32'h12345678, 32'h110, 1'b1, 1'b0, 1'b1, 4, 32'h8C220004, 32'h100};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 1'b1, 3, 32'h00221820, 32'h104};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 1'b1, 2, 32'hAC430008, 32'h108};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b1, 1'b1, 1'b1, 1, 32'h08000040, 32'h10C};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, 0, 32'h0,        32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        check_head('0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);

        // Single push, fill to full, ignored 5th word, drain in order
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            flush     = tbl[i].fl;
            in_valid  = tbl[i].iv;
            in_instr  = tbl[i].instr;
            in_pc     = tbl[i].pc;
            out_ready = tbl[i].ordy;
            #1;
            chk("tbl_in_ready",  64'(in_ready),  64'(tbl[i].e_ir));
            chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
            chk("tbl_count",     64'(count),     64'(tbl[i].e_cnt));
            check_head({tbl[i].e_pc, tbl[i].e_instr});
        end

        // Random fill/drain of 10 words across pointer wrap
        sent = 0;
        pend = $urandom();
        for (int cyc = 0; cyc < 300 && (sent < 10 || sb.size() != 0); cyc++) begin
            iv = (sent < 10) && ($urandom_range(0, 3) != 0);
            step(1'b0, iv, pend, 32'h400 + 32'(4 * sent), 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                pend = $urandom();
            end
        end
        chk("random_drained", 64'((sent == 10) && (sb.size() == 0)), 64'd1);

        // count=2, simultaneous push and pop
        step(1'b0, 1'b1, 32'h20010001, 32'h500, 1'b0, acc);
        step(1'b0, 1'b1, 32'h20020002, 32'h504, 1'b0, acc);
        step(1'b0, 1'b1, 32'h20030003, 32'h508, 1'b1, acc);
        chk("pushpop_count", 64'(sb.size()), 64'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);

        // count=3, flush with concurrent in_valid
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h3C010000 + 32'(i), 32'h600 + 32'(4 * i), 1'b0, acc);
        step(1'b1, 1'b1, 32'hDEADBEEF, 32'h700, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);

        // Empty queue, word offered with out_ready high
        step(1'b0, 1'b1, 32'h0022182A, 32'h800, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);

        // Asynchronous reset with three entries stored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h8C000000 + 32'(i), 32'h900 + 32'(4 * i), 1'b0, acc);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_reset_count", 64'(count), 64'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_count",     64'(count),     64'd0);
        check_head('0);
        sb.delete();
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b0, 1'b1, 32'h0000000C, 32'hA00, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
